// File: rtl/test_pattern_pixel_source.sv
// Synthetic RGB332 raster source: fixed-size frames with line/frame blanking and
// deterministic colour patterns, standing in for the camera capture path.
module test_pattern_pixel_source #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int HBLANK        = 24,
    parameter int VBLANK        = 6,
    parameter int BAR_HEIGHT    = 48
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [1:0] PATTERN_SEL,
    output logic [7:0] PIXEL_OUT,
    output logic [9:0] VGA_PIXEL_X,
    output logic [9:0] VGA_PIXEL_Y,
    output logic       PIXEL_VALID,
    output logic       HREF,
    output logic       VSYNC,
    output logic       FRAME_DONE,
    output logic [7:0] FRAME_COUNT
);

    localparam int LINE_PERIOD = SCREEN_WIDTH + HBLANK;
    localparam int COL_W       = $clog2(LINE_PERIOD);
    localparam int ROW_W       = $clog2(VBLANK + SCREEN_HEIGHT);

    localparam logic [COL_W-1:0] LAST_COL        = COL_W'(LINE_PERIOD - 1);
    localparam logic [COL_W-1:0] LAST_ACTIVE_COL = COL_W'(SCREEN_WIDTH - 1);
    localparam logic [COL_W-1:0] LAST_HB_COL     = COL_W'(HBLANK - 1);
    localparam logic [ROW_W-1:0] LAST_VB_LINE    = ROW_W'(VBLANK - 1);
    localparam logic [ROW_W-1:0] LAST_ROW        = ROW_W'(SCREEN_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VBLANK,
        S_ACTIVE,
        S_HBLANK,
        S_DONE
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] line;
    logic [1:0]       pattern;

    function automatic logic [7:0] pattern_pixel(input logic [1:0] sel,
                                                 input logic [9:0] x,
                                                 input logic [9:0] y);
        logic [7:0] pix;
        case (sel)
            2'd0: begin
                if (y < 10'(BAR_HEIGHT))          pix = 8'hE0;
                else if (y < 10'(2 * BAR_HEIGHT)) pix = 8'h1C;
                else                              pix = 8'h03;
            end
            2'd1:    pix = (x < 10'(SCREEN_WIDTH / 2)) ? 8'hE0 : 8'h03;
            2'd2:    pix = 8'hE0;
            default: pix = (x[3] ^ y[3]) ? 8'h03 : 8'hE0;
        endcase
        return pix;
    endfunction

    // Outputs are assigned together with the transition so that they always
    // describe the state being entered on this edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            col         <= '0;
            line        <= '0;
            pattern     <= '0;
            PIXEL_OUT   <= '0;
            VGA_PIXEL_X <= '0;
            VGA_PIXEL_Y <= '0;
            PIXEL_VALID <= 1'b0;
            HREF        <= 1'b0;
            VSYNC       <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_COUNT <= '0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    PIXEL_OUT   <= '0;
                    VGA_PIXEL_X <= '0;
                    VGA_PIXEL_Y <= '0;
                    PIXEL_VALID <= 1'b0;
                    HREF        <= 1'b0;
                    if (ENABLE) begin
                        state   <= S_VBLANK;
                        col     <= '0;
                        line    <= '0;
                        pattern <= PATTERN_SEL;
                        VSYNC   <= 1'b1;
                    end else begin
                        state   <= S_IDLE;
                        VSYNC   <= 1'b0;
                    end
                end
                S_VBLANK: begin
                    if (col == LAST_COL) begin
                        col   <= '0;
                        VSYNC <= 1'b0;
                        if (line == LAST_VB_LINE) begin
                            state       <= S_ACTIVE;
                            line        <= '0;
                            PIXEL_VALID <= 1'b1;
                            HREF        <= 1'b1;
                            VGA_PIXEL_X <= '0;
                            VGA_PIXEL_Y <= '0;
                            PIXEL_OUT   <= pattern_pixel(pattern, 10'd0, 10'd0);
                        end else begin
                            line <= line + ROW_W'(1);
                        end
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (col == LAST_ACTIVE_COL) begin
                        state       <= S_HBLANK;
                        col         <= '0;
                        PIXEL_VALID <= 1'b0;
                        HREF        <= 1'b0;
                        PIXEL_OUT   <= '0;
                        VGA_PIXEL_X <= '0;
                    end else begin
                        col         <= col + COL_W'(1);
                        VGA_PIXEL_X <= VGA_PIXEL_X + 10'd1;
                        PIXEL_OUT   <= pattern_pixel(pattern, VGA_PIXEL_X + 10'd1, VGA_PIXEL_Y);
                    end
                end
                S_HBLANK: begin
                    if (col == LAST_HB_COL) begin
                        col <= '0;
                        if (line == LAST_ROW) begin
                            state       <= S_DONE;
                            line        <= '0;
                            VGA_PIXEL_Y <= '0;
                            FRAME_DONE  <= 1'b1;
                            FRAME_COUNT <= FRAME_COUNT + 8'd1;
                        end else begin
                            state       <= S_ACTIVE;
                            line        <= line + ROW_W'(1);
                            VGA_PIXEL_Y <= VGA_PIXEL_Y + 10'd1;
                            PIXEL_VALID <= 1'b1;
                            HREF        <= 1'b1;
                            PIXEL_OUT   <= pattern_pixel(pattern, 10'd0, VGA_PIXEL_Y + 10'd1);
                        end
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_pattern_pixel_source.sv
// Bench for test_pattern_pixel_source: two full-size sources plus one reduced-size
// source (for the FRAME_COUNT wrap), each checked every cycle against a frame-position model.
module tb_test_pattern_pixel_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en  [3];
    logic [1:0] sel [3];
    logic [7:0] pix [3];
    logic [9:0] px  [3];
    logic [9:0] py  [3];
    logic       valid[3], href[3], vsync[3], done[3];
    logic [7:0] fcnt[3];

    test_pattern_pixel_source dut_a (
        .CLK(clk), .RESET(rst), .ENABLE(en[0]), .PATTERN_SEL(sel[0]),
        .PIXEL_OUT(pix[0]), .VGA_PIXEL_X(px[0]), .VGA_PIXEL_Y(py[0]),
        .PIXEL_VALID(valid[0]), .HREF(href[0]), .VSYNC(vsync[0]),
        .FRAME_DONE(done[0]), .FRAME_COUNT(fcnt[0]));

    test_pattern_pixel_source dut_b (
        .CLK(clk), .RESET(rst), .ENABLE(en[1]), .PATTERN_SEL(sel[1]),
        .PIXEL_OUT(pix[1]), .VGA_PIXEL_X(px[1]), .VGA_PIXEL_Y(py[1]),
        .PIXEL_VALID(valid[1]), .HREF(href[1]), .VSYNC(vsync[1]),
        .FRAME_DONE(done[1]), .FRAME_COUNT(fcnt[1]));

    test_pattern_pixel_source #(
        .SCREEN_WIDTH(8), .SCREEN_HEIGHT(4), .HBLANK(2), .VBLANK(1), .BAR_HEIGHT(2)
    ) dut_c (
        .CLK(clk), .RESET(rst), .ENABLE(en[2]), .PATTERN_SEL(sel[2]),
        .PIXEL_OUT(pix[2]), .VGA_PIXEL_X(px[2]), .VGA_PIXEL_Y(py[2]),
        .PIXEL_VALID(valid[2]), .HREF(href[2]), .VSYNC(vsync[2]),
        .FRAME_DONE(done[2]), .FRAME_COUNT(fcnt[2]));

    int pw[3]  = '{176, 176, 8};
    int ph[3]  = '{144, 144, 4};
    int phb[3] = '{24, 24, 2};
    int pvb[3] = '{6, 6, 1};
    int pbh[3] = '{48, 48, 2};

    int checks = 0;
    int errors = 0;

    // model: running flag, position within the frame, latched pattern, completed frames
    bit mrun[3];
    int mpos[3], mpat[3], mcnt[3];

    // observed statistics, indexed [instance][frame]
    int vs_cnt[3][4], val_cnt[3][4], red_cnt[3][4], blue_cnt[3][4];
    int red_mid[3][4], blue_mid[3][4], href_pulses[3][4];
    int href_bad[3], done_n[3], wbad[3], ibad[3], last_done[3], run_len[3];
    bit prev_href[3], prev_done[3];
    int cnt255, cnt256, a_int, pts_hit, cyc;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic int frame_len(input int i);
        return (pvb[i] + ph[i]) * (pw[i] + phb[i]) + 1;
    endfunction

    function automatic logic [7:0] model_pixel(input int i, input int pat, input int x, input int y);
        case (pat)
            0:       return (y < pbh[i]) ? 8'hE0 : ((y < 2 * pbh[i]) ? 8'h1C : 8'h03);
            1:       return (x < pw[i] / 2) ? 8'hE0 : 8'h03;
            2:       return 8'hE0;
            default: return (((x / 8) + (y / 8)) % 2 == 0) ? 8'hE0 : 8'h03;
        endcase
    endfunction

    function automatic logic [39:0] model_out(input int i);
        int lp, p, q, c;
        logic [7:0] po;
        logic [9:0] xo, yo;
        logic v, h, vs, d;
        po = '0; xo = '0; yo = '0; v = 0; h = 0; vs = 0; d = 0;
        lp = pw[i] + phb[i];
        p  = mpos[i];
        if (mrun[i]) begin
            if (p < pvb[i] * lp) begin
                vs = (p < lp);
            end else if (p < (pvb[i] + ph[i]) * lp) begin
                q  = p - pvb[i] * lp;
                c  = q % lp;
                yo = 10'(q / lp);
                if (c < pw[i]) begin
                    xo = 10'(c);
                    v  = 1'b1;
                    h  = 1'b1;
                    po = model_pixel(i, mpat[i], c, q / lp);
                end
            end else begin
                d = 1'b1;
            end
        end
        return {po, xo, yo, v, h, vs, d, 8'(mcnt[i])};
    endfunction

    task automatic model_step(input int i);
        if (!mrun[i]) begin
            if (en[i]) begin
                mrun[i] = 1'b1; mpos[i] = 0; mpat[i] = int'(sel[i]);
            end
        end else if (mpos[i] == frame_len(i) - 1) begin
            if (en[i]) begin
                mpos[i] = 0; mpat[i] = int'(sel[i]);
            end else begin
                mrun[i] = 1'b0;
            end
        end else begin
            mpos[i]++;
            if (mpos[i] == frame_len(i) - 1) mcnt[i] = (mcnt[i] + 1) % 256;
        end
    endtask

    task automatic pt(input string name, input logic [7:0] want);
        chk(name, int'(pix[0]), int'(want));
        pts_hit++;
    endtask

    always @(negedge clk) begin
        logic [39:0] act, exp;
        int fr;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mrun[i] = 1'b0; mpos[i] = 0; mcnt[i] = 0;
            end
            act = {pix[i], px[i], py[i], valid[i], href[i], vsync[i], done[i], fcnt[i]};
            exp = model_out(i);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_inst%0d t=%0t: got %h expected %h", i, $time, act, exp);
            end
            if (rst) begin
                for (int f = 0; f < 4; f++) begin
                    vs_cnt[i][f] = 0; val_cnt[i][f] = 0; red_cnt[i][f] = 0; blue_cnt[i][f] = 0;
                    red_mid[i][f] = 0; blue_mid[i][f] = 0; href_pulses[i][f] = 0;
                end
                href_bad[i] = 0; done_n[i] = 0; wbad[i] = 0; ibad[i] = 0;
                last_done[i] = -1; run_len[i] = 0; prev_href[i] = 0; prev_done[i] = 0;
                if (i == 0) begin cnt255 = -1; cnt256 = -1; a_int = -1; pts_hit = 0; end
            end else begin
                model_step(i);
                fr = (done_n[i] > 3) ? 3 : done_n[i];
                if (vsync[i]) vs_cnt[i][fr]++;
                if (valid[i]) begin
                    val_cnt[i][fr]++;
                    if (pix[i][7:5] == 3'b111) red_cnt[i][fr]++;
                    if (pix[i][1:0] == 2'b11)  blue_cnt[i][fr]++;
                    if (py[i] >= 10'd71 && py[i] <= 10'd74) begin
                        if (pix[i][7:5] == 3'b111) red_mid[i][fr]++;
                        if (pix[i][1:0] == 2'b11)  blue_mid[i][fr]++;
                    end
                end
                if (href[i] && !prev_href[i]) begin
                    href_pulses[i][fr]++; run_len[i] = 1;
                end else if (href[i]) begin
                    run_len[i]++;
                end else if (prev_href[i] && run_len[i] != pw[i]) begin
                    href_bad[i]++;
                end
                if (i == 0 && valid[0] && fr == 0) begin
                    if (px[0] == 10'd5   && py[0] == 10'd47)  pt("a_bars_5_47",   8'hE0);
                    if (px[0] == 10'd5   && py[0] == 10'd48)  pt("a_bars_5_48",   8'h1C);
                    if (px[0] == 10'd175 && py[0] == 10'd96)  pt("a_bars_175_96", 8'h03);
                end
                if (i == 0 && valid[0] && fr == 1) begin
                    if (px[0] == 10'd0   && py[0] == 10'd0)   pt("a_chk_0_0",     8'hE0);
                    if (px[0] == 10'd8   && py[0] == 10'd0)   pt("a_chk_8_0",     8'h03);
                    if (px[0] == 10'd8   && py[0] == 10'd8)   pt("a_chk_8_8",     8'hE0);
                    if (px[0] == 10'd175 && py[0] == 10'd135) pt("a_chk_175_135", 8'h03);
                    if (px[0] == 10'd175 && py[0] == 10'd143) pt("a_chk_175_143", 8'hE0);
                end
                if (done[i]) begin
                    if (prev_done[i]) wbad[i]++;
                    if (last_done[i] >= 0 && cyc - last_done[i] != frame_len(i)) ibad[i]++;
                    if (i == 0 && done_n[0] == 1) a_int = cyc - last_done[0];
                    if (i == 2 && done_n[2] == 254) cnt255 = int'(fcnt[2]);
                    if (i == 2 && done_n[2] == 255) cnt256 = int'(fcnt[2]);
                    last_done[i] = cyc;
                    done_n[i]++;
                end
                prev_href[i] = href[i];
                prev_done[i] = done[i];
            end
        end
    end

    task automatic wait_row(input int i, input int frame, input int row, input string name);
        bit found = 0;
        for (int k = 0; k < 70000 && !found; k++) begin
            @(negedge clk); #1;
            if (done_n[i] == frame && valid[i] && py[i] == 10'(row)) found = 1;
        end
        if (!found) chk(name, 0, 1);
    endtask

    task automatic wait_frames(input int i, input int n, input string name);
        bit found = 0;
        for (int k = 0; k < 70000 && !found; k++) begin
            @(negedge clk); #1;
            if (done_n[i] >= n) found = 1;
        end
        if (!found) chk(name, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin en[i] = 1'b0; sel[i] = 2'd0; end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        @(posedge clk); #2 en[0] = 1'b1;
        repeat (1300) @(posedge clk);
        #3;
        chk("a_pre_reset_valid", int'(valid[0]), 1);
        rst = 1'b1;
        en[0] = 1'b0;
        #1;
        chk("rst_pixel", int'(pix[0]), 0);
        chk("rst_x", int'(px[0]), 0);
        chk("rst_y", int'(py[0]), 0);
        chk("rst_valid", int'(valid[0]), 0);
        chk("rst_href", int'(href[0]), 0);
        chk("rst_vsync", int'(vsync[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_count", int'(fcnt[0]), 0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("idle_vsync", int'(vsync[0]), 0);
        chk("idle_valid", int'(valid[0]), 0);

        @(posedge clk); #2;
        en[0] = 1'b1; sel[0] = 2'd0;
        en[1] = 1'b1; sel[1] = 2'd1;
        en[2] = 1'b1; sel[2] = 2'd2;
        fork
            begin
                wait_row(0, 0, 70, "timeout_a_f0_row70");
                @(posedge clk); #2 sel[0] = 2'd3;
                wait_row(0, 1, 50, "timeout_a_f1_row50");
                @(posedge clk); #2 sel[0] = 2'd1;
                wait_row(0, 1, 70, "timeout_a_f1_row70");
                @(posedge clk); #2 en[0] = 1'b0;
                wait_frames(0, 2, "timeout_a_frames");
                repeat (300) @(posedge clk);
            end
            begin
                wait_row(1, 0, 10, "timeout_b_row10");
                @(posedge clk); #2 en[1] = 1'b0;
                wait_frames(1, 1, "timeout_b_frames");
            end
            begin
                wait_row(2, 256, 1, "timeout_c_f256_row1");
                @(posedge clk); #2 en[2] = 1'b0;
                wait_frames(2, 257, "timeout_c_frames");
                repeat (5) @(posedge clk);
            end
        join
        #1;

        chk("a_f0_vsync_cycles", vs_cnt[0][0], 200);
        chk("a_f0_valid_cycles", val_cnt[0][0], 25344);
        chk("a_f0_href_pulses", href_pulses[0][0], 144);
        chk("a_href_bad_len", href_bad[0], 0);
        chk("a_f1_vsync_cycles", vs_cnt[0][1], 200);
        chk("a_f1_valid_cycles", val_cnt[0][1], 25344);
        chk("a_after_vsync", vs_cnt[0][2], 0);
        chk("a_after_valid", val_cnt[0][2], 0);
        chk("a_points_seen", pts_hit, 8);
        chk("a_frames", done_n[0], 2);
        chk("a_count", int'(fcnt[0]), 2);
        chk("a_done_interval", a_int, 30001);
        chk("a_done_width", wbad[0], 0);
        chk("b_red", red_cnt[1][0], 12672);
        chk("b_blue", blue_cnt[1][0], 12672);
        chk("b_red_rows71_74", red_mid[1][0], 352);
        chk("b_blue_rows71_74", blue_mid[1][0], 352);
        chk("b_frames", done_n[1], 1);
        chk("c_frames", done_n[2], 257);
        chk("c_done_width", wbad[2], 0);
        chk("c_done_interval", ibad[2], 0);
        chk("c_count_at_255", cnt255, 255);
        chk("c_count_at_256", cnt256, 0);
        chk("c_count_final", int'(fcnt[2]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
